pcm_frame_buffer: RTL and testbench



---
 rtl/pcm_frame_buffer.sv | 170 +++++++++++++++++
 tb/tb_pcm_frame_buffer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_frame_buffer.sv
// pcm_frame_buffer: CDC capture, optional DC-blocking high-pass, ping-pong framing and valid/ready streaming of PCM samples
module pcm_frame_buffer #(
    parameter int FRAME_LEN   = 256,
    parameter int DW          = 16,
    parameter int ALPHA_SHIFT = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic [DW-1:0] pcm_i,
    input  logic          pcm_valid_i,
    input  logic          hp_bypass_i,
    input  logic          ovf_clr_i,
    output logic [DW-1:0] m_data_o,
    output logic          m_valid_o,
    input  logic          m_ready_i,
    output logic          m_first_o,
    output logic          m_last_o,
    output logic          ovf_o
);
    localparam int AW = $clog2(FRAME_LEN);
    localparam int EW = DW + 3;
    localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);
    localparam logic signed [EW-1:0] SAT_HI = {4'b0000, {(DW-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_LO = {4'b1111, {(DW-1){1'b0}}};

    typedef enum logic {FILL, DROP} wr_state_t;
    typedef enum logic [1:0] {IDLE, LOAD, SEND} rd_state_t;

    function automatic logic signed [EW-1:0] sx(input logic signed [DW-1:0] v);
        return {{(EW-DW){v[DW-1]}}, v};
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   vld_d, cap_stb, x_stb;
    logic signed [DW-1:0]   x_q, x_prev, y_prev, y;
    logic signed [EW-1:0]   acc;
    logic [DW-1:0]          mem [2*FRAME_LEN];
    logic [DW-1:0]          ram_q;
    wr_state_t              w_st, w_nxt;
    logic                   wr_bank, wr_en, set_full, drop, other_free, ovf;
    logic [AW-1:0]          wr_idx;
    logic [1:0]             full, set_mask, rel_mask;
    rd_state_t              r_st, r_nxt;
    logic                   rd_bank, rd_bank_n, rel, valid_q, valid_n, rd_en, hs;
    logic [AW-1:0]          rd_ptr, rd_ptr_n;

    assign cap_stb   = sync_q[SYNC_STAGES-1] & ~vld_d;
    assign m_data_o  = ram_q;
    assign m_valid_o = valid_q;
    assign m_first_o = valid_q & (rd_ptr == '0);
    assign m_last_o  = valid_q & (rd_ptr == LAST);
    assign ovf_o     = ovf;
    assign set_mask  = set_full ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
    assign rel_mask  = rel ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

    // Synchronize the strobe, detect its rising edge and capture the sample once per strobe
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync_q <= '0;
            vld_d  <= 1'b0;
            x_stb  <= 1'b0;
            x_q    <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pcm_valid_i};
            vld_d  <= sync_q[SYNC_STAGES-1];
            x_stb  <= cap_stb;
            if (cap_stb) x_q <= pcm_i;
        end
    end

    // First-order DC blocker with saturation; bypass passes the captured sample through
    always_comb begin
        acc = sx(x_q) - sx(x_prev) + sx(y_prev) - sx(y_prev >>> ALPHA_SHIFT);
        y   = hp_bypass_i ? x_q : (acc > SAT_HI) ? SAT_HI[DW-1:0] : (acc < SAT_LO) ? SAT_LO[DW-1:0] : acc[DW-1:0];
    end

    // Filter history advances on every sample, including bypassed and dropped ones
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            x_prev <= '0;
            y_prev <= '0;
        end else if (x_stb) begin
            x_prev <= x_q;
            y_prev <= y;
        end
    end

    // Writer next state: fill the current bank, drop whole frames while both banks are occupied
    always_comb begin
        other_free = ~full[~wr_bank] | (rel & (rd_bank != wr_bank));
        wr_en      = (w_st == FILL) & x_stb;
        set_full   = wr_en & (wr_idx == LAST);
        drop       = (w_st == DROP) & x_stb;
        w_nxt      = (w_st == FILL) ? ((set_full & ~other_free) ? DROP : FILL) : (rel ? FILL : DROP);
    end

    // Writer state, bank bookkeeping and sticky overflow flag (a drop beats a clear)
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            w_st    <= FILL;
            wr_bank <= 1'b0;
            wr_idx  <= '0;
            full    <= 2'b00;
            ovf     <= 1'b0;
        end else begin
            w_st <= w_nxt;
            if (wr_en) wr_idx <= wr_idx + 1'b1;
            if (set_full && other_free) wr_bank <= ~wr_bank;
            else if (w_st == DROP && rel) wr_bank <= rd_bank;
            full <= (full | set_mask) & ~rel_mask;
            ovf  <= drop | (ovf & ~ovf_clr_i);
        end
    end

    // Frame storage: both banks in one array addressed by {bank, index}
    always_ff @(posedge sys_clk) begin
        if (wr_en) mem[{wr_bank, wr_idx}] <= y;
    end

    // Reader next state: banks are served alternately, matching the writer's fill order
    always_comb begin
        r_nxt     = r_st;
        rd_bank_n = rd_bank;
        rd_ptr_n  = rd_ptr;
        valid_n   = valid_q;
        rel       = 1'b0;
        hs        = valid_q & m_ready_i;
        case (r_st)
            IDLE: begin
                rd_ptr_n = '0;
                if (full[rd_bank]) r_nxt = LOAD;
            end
            LOAD: begin
                r_nxt   = SEND;
                valid_n = 1'b1;
            end
            SEND: if (hs) begin
                if (rd_ptr == LAST) begin
                    rel       = 1'b1;
                    rd_bank_n = ~rd_bank;
                    rd_ptr_n  = '0;
                    r_nxt     = full[~rd_bank] ? SEND : IDLE;
                    valid_n   = full[~rd_bank];
                end else begin
                    rd_ptr_n = rd_ptr + 1'b1;
                end
            end
            default: r_nxt = IDLE;
        endcase
        rd_en = (r_nxt == SEND);
    end

    // Reader state and output register; the read address tracks the next beat so a stall re-reads the held beat
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_st    <= IDLE;
            rd_bank <= 1'b0;
            rd_ptr  <= '0;
            valid_q <= 1'b0;
            ram_q   <= '0;
        end else begin
            r_st    <= r_nxt;
            rd_bank <= rd_bank_n;
            rd_ptr  <= rd_ptr_n;
            valid_q <= valid_n;
            if (rd_en) ram_q <= mem[{rd_bank_n, rd_ptr_n}];
        end
    end
endmodule

// File: tb/tb_pcm_frame_buffer.sv
// tb_pcm_frame_buffer: scoreboard bench for pcm_frame_buffer
module tb_pcm_frame_buffer;
    logic        sys_clk, sys_rst;
    logic [15:0] pcm_i;
    logic        pcm_valid_i, hp_bypass_i, ovf_clr_i;
    logic [15:0] m_data_o;
    logic        m_valid_o, m_ready_i, m_first_o, m_last_o, ovf_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          rdy_mode = 1;
    logic [17:0] exp_q[$];
    logic [17:0] e_beat, held;
    logic        stalled = 0;
    logic [15:0] last_out = '0;
    int          mx = 0, my = 0, pos = 0;

    pcm_frame_buffer dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .pcm_i(pcm_i), .pcm_valid_i(pcm_valid_i),
        .hp_bypass_i(hp_bypass_i), .ovf_clr_i(ovf_clr_i), .m_data_o(m_data_o), .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i), .m_first_o(m_first_o), .m_last_o(m_last_o), .ovf_o(ovf_o)
    );

    initial sys_clk = 0;
    always #10 sys_clk = ~sys_clk;

    // Consumer ready: 0 = always ready, 1 = never ready, 2 = random 30 % duty
    initial begin
        m_ready_i = 0;
        forever begin
            @(posedge sys_clk);
            #2;
            m_ready_i = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : ($urandom_range(0, 99) < 30);
        end
    end

    // Output monitor: pop expected beats on handshakes, check held beats while stalled
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (stalled) begin
                n_tests++;
                if (m_valid_o !== 1'b1 || {m_first_o, m_last_o, m_data_o} !== held) begin
                    n_fail++;
                    $display("FAIL stall_hold valid=%b got=%h held=%h", m_valid_o, {m_first_o, m_last_o, m_data_o}, held);
                end
            end
            if (m_valid_o && m_ready_i) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat_unexpected got=%h", {m_first_o, m_last_o, m_data_o});
                end else begin
                    e_beat = exp_q.pop_front();
                    if ({m_first_o, m_last_o, m_data_o} !== e_beat) begin
                        n_fail++;
                        $display("FAIL beat got first/last/data=%h exp=%h", {m_first_o, m_last_o, m_data_o}, e_beat);
                    end
                    last_out = m_data_o;
                end
            end
            stalled = m_valid_o && !m_ready_i;
            held    = {m_first_o, m_last_o, m_data_o};
        end else begin
            stalled = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic model_reset();
        mx = 0;
        my = 0;
        pos = 0;
        exp_q.delete();
    endtask

    // Drive one strobe and push the modelled output if the sample is expected to be kept
    task automatic send_sample(input int v, input bit push, input int gap);
        int yv;
        pcm_i = v[15:0];
        pcm_valid_i = 1;
        tick(4);
        pcm_valid_i = 0;
        tick(gap - 4);
        if (hp_bypass_i) yv = v;
        else begin
            yv = v - mx + my - (my >>> 6);
            if (yv > 32767) yv = 32767;
            if (yv < -32768) yv = -32768;
        end
        mx = v;
        my = yv;
        if (push) begin
            exp_q.push_back({pos == 0, pos == 255, yv[15:0]});
            pos = (pos + 1) % 256;
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            tick(1);
            c++;
        end
        tick(4);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s drain_timeout left=%0d exp=0", name, exp_q.size());
        end
    endtask

    task automatic check_idle_zero(input string name);
        n_tests++;
        if ({m_valid_o, m_first_o, m_last_o, ovf_o, m_data_o} !== 20'h0) begin
            n_fail++;
            $display("FAIL %s outputs valid=%b first=%b last=%b ovf=%b data=%h exp all 0",
                     name, m_valid_o, m_first_o, m_last_o, ovf_o, m_data_o);
        end
    endtask

    task automatic check_ovf(input logic exp, input string name);
        n_tests++;
        if (ovf_o !== exp) begin
            n_fail++;
            $display("FAIL %s ovf=%b exp=%b", name, ovf_o, exp);
        end
    endtask

    task automatic test_reset();
        sys_rst = 1;
        tick(3);
        check_idle_zero("reset");
        sys_rst = 0;
        tick(3);
        check_idle_zero("after_reset");
    endtask

    task automatic test_ramp();
        hp_bypass_i = 1;
        rdy_mode = 0;
        for (int i = 0; i < 256; i++) send_sample(i, 1, 64);
        wait_drain(2000, "ramp");
        check_ovf(0, "ramp_ovf");
    endtask

    task automatic test_dc_blocker();
        hp_bypass_i = 0;
        rdy_mode = 0;
        for (int i = 0; i < 512; i++) send_sample(1000, 1, 8);
        wait_drain(2000, "dc");
        n_tests++;
        if ($signed(last_out) > 64 || $signed(last_out) < -64) begin
            n_fail++;
            $display("FAIL dc_settle y=%0d exp |y|<=64", $signed(last_out));
        end
    endtask

    task automatic test_saturation();
        hp_bypass_i = 0;
        rdy_mode = 0;
        for (int i = 0; i < 300; i++) send_sample(-32768, 1, 8);
        for (int i = 0; i < 212; i++) send_sample(32767, 1, 8);
        wait_drain(2000, "sat");
    endtask

    task automatic test_backpressure();
        hp_bypass_i = 1;
        rdy_mode = 2;
        for (int i = 0; i < 512; i++) send_sample(i, 1, 8);
        wait_drain(6000, "backpressure");
        check_ovf(0, "bp_ovf");
        rdy_mode = 0;
    endtask

    task automatic test_overflow();
        hp_bypass_i = 1;
        rdy_mode = 1;
        for (int i = 0; i < 512; i++) send_sample(i, 1, 8);
        check_ovf(0, "ovf_before_513");
        send_sample(512, 0, 8);
        check_ovf(1, "ovf_at_513");
        for (int i = 513; i < 700; i++) send_sample(i, 0, 8);
        rdy_mode = 0;
        wait_drain(3000, "ovf_drain");
        for (int i = 0; i < 256; i++) send_sample(1000 + i, 1, 8);
        wait_drain(3000, "ovf_refill");
        check_ovf(1, "ovf_sticky");
        ovf_clr_i = 1;
        tick(1);
        ovf_clr_i = 0;
        check_ovf(0, "ovf_clear");
    endtask

    task automatic test_reset_mid_frame();
        hp_bypass_i = 0;
        rdy_mode = 1;
        for (int i = 0; i < 356; i++) send_sample(500 + 7 * i, 1, 8);
        n_tests++;
        if (m_valid_o !== 1'b1 || m_first_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset valid=%b first=%b exp 1 1", m_valid_o, m_first_o);
        end
        #3;
        sys_rst = 1;
        #1;
        check_idle_zero("mid_reset");
        model_reset();
        tick(3);
        sys_rst = 0;
        rdy_mode = 0;
        tick(3);
        for (int i = 0; i < 256; i++) send_sample(2000 - 3 * i, 1, 8);
        wait_drain(2000, "post_reset");
    endtask

    initial begin
        sys_rst = 1;
        pcm_i = 0;
        pcm_valid_i = 0;
        hp_bypass_i = 1;
        ovf_clr_i = 0;
        test_reset();
        test_ramp();
        test_dc_blocker();
        test_saturation();
        test_backpressure();
        test_overflow();
        test_reset_mid_frame();
        tick(20);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
